nbit_serial_add: RTL

NBIT_SERIAL_ADD -- requirements
Module: nbit_serial_add

---
 rtl/nbit_serial_add.sv | 97 +++++++++
 1 files changed

// File: rtl/nbit_serial_add.sv
// Bit-serial N-bit adder: one full adder and a registered carry, LSB first.
// {c_out, sum} = a + b + c_in after N RUN cycles, then a one-cycle DONE.
module nbit_serial_add #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         c_out
);

  localparam int unsigned CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [N-1:0]   a_sh;
  logic [N-1:0]   b_sh;
  logic [N-1:0]   work;
  logic           carry;
  logic [CW-1:0]  cnt;
  logic           fa_s;
  logic           fa_c;
  logic           last_bit;

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    fa_s      = a_sh[0] ^ b_sh[0] ^ carry;
    fa_c      = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
    last_bit  = (cnt == CW'(N - 1));
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      work  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      c_out <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= c_in;
            cnt   <= '0;
          end
        end
        RUN: begin
          // Result enters at the MSB so bit 0 lands in place after N shifts.
          work  <= {fa_s, work[N-1:1]};
          carry <= fa_c;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          cnt   <= cnt + 1'b1;
          if (last_bit) begin
            sum   <= {fa_s, work[N-1:1]};
            c_out <= fa_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
